// File: rtl/fully_connect_layer.sv
// Dense layer engine: snapshots the feature vector and weight matrix on start,
// then produces one signed dot-product row per clock into output_vector.
module fully_connect_layer #(
    parameter int BITWIDTH = 32,
    parameter int IN_LEN   = 10,
    parameter int OUT_LEN  = 10
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    input  logic [IN_LEN-1:0][BITWIDTH-1:0]             featuremap3,
    input  logic [OUT_LEN-1:0][IN_LEN-1:0][BITWIDTH-1:0] connect_matrix,
    output logic [OUT_LEN-1:0][BITWIDTH-1:0]            output_vector,
    output logic                                        busy,
    output logic                                        done
);

    localparam int CNT_W  = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
    localparam int PROD_W = 2 * BITWIDTH;
    localparam int ACC_W  = PROD_W + ((IN_LEN > 1) ? $clog2(IN_LEN) : 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                                       state_q, state_d;
    logic [CNT_W-1:0]                             cnt_q, cnt_d;
    logic [IN_LEN-1:0][BITWIDTH-1:0]              fm_q, fm_d;
    logic [OUT_LEN-1:0][IN_LEN-1:0][BITWIDTH-1:0] mat_q, mat_d;
    logic [OUT_LEN-1:0][BITWIDTH-1:0]             out_q, out_d;
    logic                                         done_q, done_d;

    logic [IN_LEN-1:0][BITWIDTH-1:0] row_w;
    logic [IN_LEN-1:0][PROD_W-1:0]   prod;
    logic [ACC_W-1:0]                acc;
    logic                            unused_acc_hi;

    // Weight row currently being reduced comes from the snapshot, never the live inputs
    assign row_w = mat_q[cnt_q];

    // One full-width signed multiplier per input column; operands sign-extended
    // explicitly so the product width never depends on expression context
    for (genvar j = 0; j < IN_LEN; j++) begin : g_mul
        logic [PROD_W-1:0] a_ext, b_ext;
        assign a_ext   = {{BITWIDTH{row_w[j][BITWIDTH-1]}}, row_w[j]};
        assign b_ext   = {{BITWIDTH{fm_q[j][BITWIDTH-1]}}, fm_q[j]};
        assign prod[j] = $signed(a_ext) * $signed(b_ext);
    end

    // Adder tree over the products in a guard-bit accumulator
    always_comb begin
        acc = '0;
        for (int j = 0; j < IN_LEN; j++)
            acc = acc + {{(ACC_W-PROD_W){prod[j][PROD_W-1]}}, prod[j]};
    end

    // Only the low BITWIDTH bits are kept (modulo wrap); the guard bits exist for exactness
    assign unused_acc_hi = ^acc[ACC_W-1:BITWIDTH];

    // Next-state, snapshot capture and row write-back
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fm_d    = fm_q;
        mat_d   = mat_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    fm_d    = featuremap3;
                    mat_d   = connect_matrix;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                out_d[cnt_q] = acc[BITWIDTH-1:0];
                if (cnt_q == CNT_W'(OUT_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; async reset aborts any run in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fm_q    <= '0;
            mat_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fm_q    <= fm_d;
            mat_q   <= mat_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign output_vector = out_q;
    assign busy          = (state_q == RUN);
    assign done          = done_q;

endmodule

// File: tb/tb_fully_connect_layer.sv
// Self-checking bench for fully_connect_layer: directed table, random vectors
// against an arithmetic reference, snapshot/busy-start, reset mid-run, back-to-back.
module tb_fully_connect_layer;

    localparam int BW = 32;
    localparam int IL = 10;
    localparam int OL = 10;

    typedef logic [IL-1:0][BW-1:0]         fmv_t;
    typedef logic [OL-1:0][IL-1:0][BW-1:0] mat_t;
    typedef logic [OL-1:0][BW-1:0]         vec_t;

    typedef struct {
        string nm;
        fmv_t  fm;
        mat_t  m;
        vec_t  exp;
    } vec_rec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    fmv_t featuremap3;
    mat_t connect_matrix;
    vec_t output_vector;
    logic busy, done;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t prev_exp;

    fully_connect_layer #(.BITWIDTH(BW), .IN_LEN(IL), .OUT_LEN(OL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .featuremap3(featuremap3), .connect_matrix(connect_matrix),
        .output_vector(output_vector), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference: signed dot products in 64-bit integers, keep low BW bits
    function automatic vec_t model(input fmv_t fm, input mat_t m);
        vec_t r;
        for (int i = 0; i < OL; i++) begin
            longint s = 0;
            for (int j = 0; j < IL; j++)
                s += longint'($signed(m[i][j])) * longint'($signed(fm[j]));
            r[i] = s[BW-1:0];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [OL*BW-1:0] act, input logic [OL*BW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Start a run, follow it cycle by cycle, check ordering, latency and final result.
    // Returns in the cycle where done is (expected) high.
    task automatic do_run(input string nm, input fmv_t fm, input mat_t m, input vec_t exp, input bit poke);
        int   lat;
        vec_t prog;
        featuremap3    = fm;
        connect_matrix = m;
        start          = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        if (poke) begin
            featuremap3    = '1;
            connect_matrix = '1;
        end
        chk({nm, " busy@start"}, OL*BW'(busy), OL*BW'(1));
        while (!done && lat < 3*OL) begin
            @(posedge clk); #1;
            lat++;
            if (poke) start = (lat == 4);
            for (int i = 0; i < OL; i++) prog[i] = (i < lat) ? exp[i] : prev_exp[i];
            if (lat <= OL) chk($sformatf("%s row progress c%0d", nm, lat), output_vector, prog);
            if (!done) chk($sformatf("%s busy c%0d", nm, lat), OL*BW'(busy), OL*BW'(1));
        end
        start = 1'b0;
        chk({nm, " latency"}, OL*BW'(lat), OL*BW'(OL));
        chk({nm, " busy@done"}, OL*BW'(busy), '0);
        chk({nm, " result"}, output_vector, exp);
        prev_exp = exp;
    endtask

    task automatic done_drops(input string nm);
        @(posedge clk); #1;
        chk({nm, " done pulse width"}, OL*BW'(done), '0);
        chk({nm, " idle after done"}, OL*BW'(busy), '0);
    endtask

    vec_rec_t tbl[6];

    initial begin
        fmv_t fm;
        mat_t m;
        int   seen;

        // ---- table setup ----
        for (int k = 0; k < 6; k++) begin
            tbl[k].fm = '0; tbl[k].m = '0; tbl[k].exp = '0;
        end
        tbl[0].nm = "identity";
        for (int i = 0; i < OL; i++) begin
            tbl[0].fm[i] = BW'(i); tbl[0].m[i][i] = 32'd1; tbl[0].exp[i] = BW'(i);
        end
        tbl[1].nm = "rowsum";
        for (int j = 0; j < IL; j++) tbl[1].fm[j] = BW'(j + 1);
        for (int i = 0; i < OL; i++) begin
            for (int j = 0; j < IL; j++) tbl[1].m[i][j] = 32'd1;
            tbl[1].exp[i] = 32'd55;
        end
        tbl[2].nm = "signed_wrap";
        tbl[2].m[0][0] = 32'hFFFFFFFD;
        tbl[2].m[1][0] = 32'h00010000;
        tbl[2].fm[0]   = 32'h00010000;
        tbl[2].fm[0]   = 32'd7;
        tbl[2].exp[0]  = 32'hFFFFFFEB;
        tbl[2].exp[1]  = 32'd7 << 16;
        for (int k = 3; k < 6; k++) begin
            tbl[k].nm = $sformatf("random%0d", k - 3);
            for (int j = 0; j < IL; j++) tbl[k].fm[j] = $urandom;
            for (int i = 0; i < OL; i++)
                for (int j = 0; j < IL; j++)
                    tbl[k].m[i][j] = (k == 3) ? BW'($urandom_range(0, 15)) - 32'd8 : $urandom;
            tbl[k].exp = model(tbl[k].fm, tbl[k].m);
        end

        // ---- reset state ----
        rst_n = 1'b0; start = 1'b0; featuremap3 = '0; connect_matrix = '0; prev_exp = '0;
        #12;
        chk("reset output_vector", output_vector, '0);
        chk("reset busy", OL*BW'(busy), '0);
        chk("reset done", OL*BW'(done), '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- table-driven runs ----
        for (int k = 0; k < 6; k++) begin
            do_run(tbl[k].nm, tbl[k].fm, tbl[k].m, tbl[k].exp, 1'b0);
            done_drops(tbl[k].nm);
        end

        // wrap case on its own: 0x10000 * 0x10000 wraps to 0
        fm = '0; m = '0;
        fm[0] = 32'h00010000; m[1][0] = 32'h00010000;
        do_run("wrap", fm, m, '0, 1'b0);
        done_drops("wrap");

        // ---- snapshot + start while busy ----
        do_run("snapshot", tbl[1].fm, tbl[1].m, tbl[1].exp, 1'b1);
        done_drops("snapshot");
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (busy || done) seen++;
        end
        chk("no restart after busy start", OL*BW'(seen), '0);

        // ---- reset mid-run ----
        featuremap3 = tbl[4].fm; connect_matrix = tbl[4].m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrun reset outputs", output_vector, '0);
        chk("midrun reset busy", OL*BW'(busy), '0);
        chk("midrun reset done", OL*BW'(done), '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev_exp = '0;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("no activity after reset release", OL*BW'(seen), '0);
        do_run("after reset", tbl[4].fm, tbl[4].m, tbl[4].exp, 1'b0);
        done_drops("after reset");

        // ---- back-to-back: start in the done cycle ----
        do_run("b2b first", tbl[3].fm, tbl[3].m, tbl[3].exp, 1'b0);
        chk("b2b done before restart", OL*BW'(done), OL*BW'(1));
        do_run("b2b second", tbl[5].fm, tbl[5].m, tbl[5].exp, 1'b0);
        done_drops("b2b second");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fully_connect_layer.md
Name: fully_connect_layer

Overview:
- Fully-connected (dense) layer of the CNN accelerator.
- Sits after the third feature-map stage.
- Multiplies the input feature vector by a weight matrix: output_vector[i] = sum over j of connect_matrix[i][j] * featuremap3[j].
- Sequential engine: one output row per clock, start/busy/done handshake, result registers held until the next run.

Parameters:
- BITWIDTH, 32, width of every feature, weight and output element.
- IN_LEN, 10, number of input features (columns of connect_matrix).
- OUT_LEN, 10, number of outputs (rows of connect_matrix).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a computation; sampled on rising edge while idle.
- featuremap3  input  [IN_LEN-1:0][BITWIDTH-1:0]  input feature vector.
- connect_matrix  input  [OUT_LEN-1:0][IN_LEN-1:0][BITWIDTH-1:0]  weights; first index = output row i, second = input column j.
- output_vector  output  [OUT_LEN-1:0][BITWIDTH-1:0]  registered result vector.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse when all OUT_LEN results are valid.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, takes effect immediately, independent of clk):
  - output_vector all zero, busy=0, done=0.
  - Row counter = 0; state = IDLE; snapshot registers cleared.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE, start=1 at edge E0:
  - Snapshot featuremap3 and connect_matrix into internal registers.
  - Row counter = 0; enter RUN; busy=1 from E0.
  - Inputs may change freely after E0.
- RUN, edge Ek (k=1..OUT_LEN): write output_vector[k-1] = dot product of snapshot row k-1 with snapshot feature vector; increment row counter.
- At edge E_OUT_LEN (last row written):
  - Return to IDLE; busy=0; done=1 for exactly one cycle.
  - All output_vector elements are valid while done=1.
- Latency: OUT_LEN cycles from start edge to done (10 with defaults).
- start while busy: ignored, no effect on the running computation.
- start while done=1 (already IDLE): accepted; a new run begins.
- output_vector elements not yet rewritten keep prior values during a new run. Rows are updated in order 0..OUT_LEN-1.
- Arithmetic:
  - Operands are signed two's complement.
  - Each product is a full 2*BITWIDTH-bit value.
  - Products are summed in an accumulator of at least 2*BITWIDTH+ceil(log2(IN_LEN)) bits.
  - Stored result = low BITWIDTH bits of the sum (modulo 2^BITWIDTH wrap, no saturation).
- Datapath: IN_LEN parallel multipliers plus an adder tree, registered at output_vector. Combinational path is snapshot registers -> output register; no input-to-output combinational path.
- Reset mid-RUN: computation aborted, all outputs zero, no done pulse; start required again after release.
- IN_LEN and OUT_LEN may differ; the row counter width is sized from OUT_LEN.

Test Plan:
- Identity: featuremap3[j]=j, connect_matrix[i][i]=1, all others 0, start pulse -> done exactly 10 cycles after the start edge; output_vector[i]=i for i=0..9; busy high during those 10 cycles.
- Row sums: all weights 1, featuremap3[j]=j+1 -> every output_vector[i]=55; rows update one per cycle in order 0..9.
- Signed and overflow:
  - connect_matrix[0][0]=-3 (0xFFFFFFFD), featuremap3[0]=7, others 0 -> output_vector[0]=0xFFFFFFEB (-21).
  - connect_matrix[1][0]=0x10000, featuremap3[0]=0x10000 -> output_vector[1]=0 (wrap).
- Snapshot and busy start: change featuremap3 to all 0xFF the cycle after start, and pulse start mid-run -> results reflect the original inputs; a single done pulse; no restart.
- Reset mid-run: assert rst_n=0 at cycle 4 of a run, asynchronously between edges -> outputs, busy and done go 0 immediately; no done after release. A fresh start then produces the correct results.
- Back-to-back: assert start in the cycle done=1 with a new matrix -> second run accepted; second done 10 cycles later with the new results.
